// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: RV32I opcodes, immediate type,
// encoder FSM states and the instruction-format classification.
package instr_encoder_pkg;

  typedef enum logic [6:0] {
    OP_RTYPE       = 7'b0110011,
    OP_ITYPE_LOGIC = 7'b0010011,
    OP_ITYPE_LOAD  = 7'b0000011,
    OP_ITYPE_JALR  = 7'b1100111,
    OP_STYPE       = 7'b0100011,
    OP_BTYPE       = 7'b1100011,
    OP_JTYPE       = 7'b1101111,
    OP_UTYPE_AUIPC = 7'b0010111,
    OP_UTYPE_LUI   = 7'b0110111,
    OP_FENCE       = 7'b0001111
  } opcode_t;

  typedef logic [31:0] imm_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_WRITE
  } enc_state_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_I_SHIFT,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } instr_fmt_t;

  typedef struct packed {
    logic       known;
    instr_fmt_t fmt;
  } fmt_info_t;

  // Maps an opcode (and funct3 for the shift-immediate forms) to its packing
  // format; known = 0 flags opcodes the encoder does not support.
  function automatic fmt_info_t decode_fmt(opcode_t op, logic [2:0] funct3);
    fmt_info_t info;
    info.known = 1'b1;
    info.fmt   = FMT_R;
    case (op)
      OP_RTYPE:       info.fmt = FMT_R;
      OP_ITYPE_LOGIC: info.fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_I_SHIFT : FMT_I;
      OP_ITYPE_LOAD,
      OP_ITYPE_JALR,
      OP_FENCE:       info.fmt = FMT_I;
      OP_STYPE:       info.fmt = FMT_S;
      OP_BTYPE:       info.fmt = FMT_B;
      OP_JTYPE:       info.fmt = FMT_J;
      OP_UTYPE_AUIPC,
      OP_UTYPE_LUI:   info.fmt = FMT_U;
      default:        info.known = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake and instruction-memory write bus of the encoder.
// master = program source / memory model side, slave = encoder side.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 10
);
  import instr_encoder_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  opcode_t               opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  imm_t                  imm;

  logic                  mem_wr_en;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/instr_encoder_packer.sv
// instr_packer: combinational field-to-word packing for RV32I formats.
// Optional macro IMM_RANGE_CHECK_EN: when defined, imm_ok reports whether the
// immediate fits its format; otherwise imm_ok is always 1 and the immediate
// is silently truncated.
module instr_packer
  import instr_encoder_pkg::*;
(
  input  instr_fmt_t  fmt,
  input  opcode_t     opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  imm_t        imm,
  output logic [31:0] word,
  output logic        imm_ok
);

  // Place each field at its bit position for the selected format
  always_comb begin
    word = 32'h0;
    case (fmt)
      FMT_R:       word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:       word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_I_SHIFT: word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:       word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:       word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:       word = {imm[31:12], rd, opcode};
      FMT_J:       word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:     word = 32'h0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be representable: sign bits above the field all equal,
  // branch/jump offsets even, upper-immediate low 12 bits zero
  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_I_SHIFT, FMT_S:
        imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
      FMT_B:
        imm_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      FMT_J:
        imm_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      FMT_U:
        imm_ok = ~(|imm[11:0]);
      default:
        imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts decoded instruction fields, packs them into RV32I
// words and writes them to sequential instruction-memory word addresses.
// Optional macro IMM_RANGE_CHECK_EN: enables immediate range checking and
// the sticky imm_err flag; otherwise imm_err is tied low.
//
// state    | meaning
// ST_IDLE  | waiting for a field bundle (in_ready = !full)
// ST_PACK  | captured bundle is packed into mem_wdata or rejected
// ST_WRITE | mem_wr_en held with stable addr/data until mem_ready
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  instr_encoder_if.slave      bus,
  output logic                full,
  output logic                opcode_err,
  output logic                imm_err,
  output logic [ADDR_WIDTH:0] count
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  enc_state_t            state;
  logic                  in_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full_q;
  logic                  op_err_q;

  opcode_t               op_q;
  logic [2:0]            f3_q;
  logic [6:0]            f7_q;
  logic [4:0]            rd_q;
  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  imm_t                  imm_q;

  fmt_info_t             fmt_info;
  logic [31:0]           pk_word;
  logic                  pk_imm_ok;

`ifdef IMM_RANGE_CHECK_EN
  logic                  imm_err_q;
`endif

  assign fmt_info = decode_fmt(op_q, f3_q);

  instr_packer u_packer (
    .fmt    (fmt_info.fmt),
    .opcode (op_q),
    .funct3 (f3_q),
    .funct7 (f7_q),
    .rd     (rd_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .imm    (imm_q),
    .word   (pk_word),
    .imm_ok (pk_imm_ok)
  );

  // Encoder sequencing: capture, pack/reject, write with backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      count_q    <= '0;
      full_q     <= 1'b0;
      op_err_q   <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      imm_err_q  <= 1'b0;
`endif
      op_q       <= OP_RTYPE;
      f3_q       <= 3'h0;
      f7_q       <= 7'h0;
      rd_q       <= 5'h0;
      rs1_q      <= 5'h0;
      rs2_q      <= 5'h0;
      imm_q      <= 32'h0;
    end else if (clear) begin
      // Discards any in-flight bundle; a bundle offered now is not taken
      state      <= ST_IDLE;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      op_err_q   <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      imm_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            op_q       <= bus.opcode;
            f3_q       <= bus.funct3;
            f7_q       <= bus.funct7;
            rd_q       <= bus.rd;
            rs1_q      <= bus.rs1;
            rs2_q      <= bus.rs2;
            imm_q      <= bus.imm;
            in_ready_q <= 1'b0;
            state      <= ST_PACK;
          end
        end
        ST_PACK: begin
          if (!fmt_info.known) begin
            op_err_q   <= 1'b1;
            in_ready_q <= !full_q;
            state      <= ST_IDLE;
          end else if (!pk_imm_ok) begin
`ifdef IMM_RANGE_CHECK_EN
            imm_err_q  <= 1'b1;
`endif
            in_ready_q <= !full_q;
            state      <= ST_IDLE;
          end else begin
            wdata_q    <= pk_word;
            wr_en_q    <= 1'b1;
            state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ready) begin
            wr_en_q    <= 1'b0;
            addr_q     <= addr_q + 1'b1;
            count_q    <= count_q + 1'b1;
            // Wrapping to address 0 means every word has been written once
            if (addr_q == ADDR_LAST) begin
              full_q <= 1'b1;
            end
            in_ready_q <= !(full_q || (addr_q == ADDR_LAST));
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= !full_q;
          wr_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign full          = full_q;
  assign opcode_err    = op_err_q;
  assign count         = count_q;

`ifdef IMM_RANGE_CHECK_EN
  assign imm_err = imm_err_q;
`else
  assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder. Honors IMM_RANGE_CHECK_EN
// for the out-of-range immediate vector.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic s_clear = 1'b0;

  logic        full, opcode_err, imm_err;
  logic [10:0] count;
  logic        s_full, s_opcode_err, s_imm_err;
  logic [2:0]  s_count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder_if #(.ADDR_WIDTH(10)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(2))  sbus ();

  instr_encoder #(.ADDR_WIDTH(10)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .bus        (bus.slave),
    .full       (full),
    .opcode_err (opcode_err),
    .imm_err    (imm_err),
    .count      (count)
  );

  instr_encoder #(.ADDR_WIDTH(2)) u_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (s_clear),
    .bus        (sbus.slave),
    .full       (s_full),
    .opcode_err (s_opcode_err),
    .imm_err    (s_imm_err),
    .count      (s_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_clear;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          exp_wr;
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
    int          exp_count;
    bit          exp_oerr;
    bit          exp_ierr;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
    bus.opcode = opcode_t'(op);
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rd     = rd;
    bus.rs1    = rs1;
    bus.rs2    = rs2;
    bus.imm    = imm;
  endtask

  // Offer one bundle, observe the resulting write (if any) until in_ready returns
  task automatic run_vec(input int idx, input vec_t v);
    bit ready_ok = 0;
    bit wrote = 0;
    bit done = 0;
    logic [31:0] a = 0;
    logic [31:0] d = 0;
    if (v.do_clear) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
    end
    for (int w = 0; w < 10; w++) begin
      if (bus.in_ready) begin
        ready_ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("vec_in_ready", idx, {31'h0, ready_ok}, 32'h1);
    drive_fields(v.op, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        wrote = 1;
        a = {22'h0, bus.mem_addr};
        d = bus.mem_wdata;
      end
      if (bus.in_ready) begin
        done = 1;
        break;
      end
    end
    check("vec_done", idx, {31'h0, done}, 32'h1);
    check("vec_wrote", idx, {31'h0, wrote}, {31'h0, v.exp_wr});
    if (v.exp_wr) begin
      check("vec_addr", idx, a, {22'h0, v.exp_addr});
      check("vec_data", idx, d, v.exp_data);
    end
    check("vec_count", idx, {21'h0, count}, v.exp_count);
    check("vec_opcode_err", idx, {31'h0, opcode_err}, {31'h0, v.exp_oerr});
    check("vec_imm_err", idx, {31'h0, imm_err}, {31'h0, v.exp_ierr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nwr;
    //            clr op      f3    f7        rd  rs1 rs2 imm            wr addr data           cnt oe ie
    vecs[0]  = '{1, 7'h33, 3'h0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 1, 10'd0,  32'h002081B3, 1,  0, 0};
    vecs[1]  = '{1, 7'h13, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 10'd0,  32'hFFF00093, 1,  0, 0};
    vecs[2]  = '{0, 7'h23, 3'h2, 7'h00, 5'd0, 5'd2, 5'd5, 32'h0000_0008, 1, 10'd1,  32'h00512423, 2,  0, 0};
    vecs[3]  = '{0, 7'h63, 3'h0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 10'd2,  32'hFE208EE3, 3,  0, 0};
    vecs[4]  = '{0, 7'h6F, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1, 10'd3,  32'h001000EF, 4,  0, 0};
    vecs[5]  = '{0, 7'h37, 3'h0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1, 10'd4,  32'h123452B7, 5,  0, 0};
    vecs[6]  = '{0, 7'h7F, 3'h3, 7'h11, 5'd9, 5'd8, 5'd7, 32'h0000_0010, 0, 10'd0,  32'h00000000, 5,  1, 0};
    vecs[7]  = '{0, 7'h17, 3'h0, 7'h00, 5'd7, 5'd0, 5'd0, 32'hABCD_E000, 1, 10'd5,  32'hABCDE397, 6,  1, 0};
    vecs[8]  = '{0, 7'h03, 3'h2, 7'h00, 5'd6, 5'd10,5'd0, 32'hFFFF_FFF8, 1, 10'd6,  32'hFF852303, 7,  1, 0};
    vecs[9]  = '{0, 7'h67, 3'h0, 7'h00, 5'd0, 5'd1, 5'd0, 32'h0000_0000, 1, 10'd7,  32'h00008067, 8,  1, 0};
    vecs[10] = '{0, 7'h0F, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_00FF, 1, 10'd8,  32'h0FF0000F, 9,  1, 0};
    vecs[11] = '{0, 7'h13, 3'h5, 7'h20, 5'd4, 5'd5, 5'd0, 32'h0000_0003, 1, 10'd9,  32'h4032D213, 10, 1, 0};
    vecs[12] = '{0, 7'h33, 3'h0, 7'h20, 5'd5, 5'd6, 5'd7, 32'hDEAD_BEEF, 1, 10'd10, 32'h407302B3, 11, 1, 0};
    vecs[13] = '{0, 7'h23, 3'h2, 7'h00, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 1, 10'd11, 32'hFE512E23, 12, 1, 0};
`ifdef IMM_RANGE_CHECK_EN
    vecs[14] = '{1, 7'h13, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 0, 10'd0,  32'h00000000, 0,  0, 1};
`else
    vecs[14] = '{1, 7'h13, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1, 10'd0,  32'h80000093, 1,  0, 0};
`endif

    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    drive_fields(7'h33, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    sbus.in_valid  = 1'b0;
    sbus.mem_ready = 1'b1;
    sbus.opcode    = OP_RTYPE;
    sbus.funct3    = 3'h0;
    sbus.funct7    = 7'h00;
    sbus.rd        = 5'd3;
    sbus.rs1       = 5'd1;
    sbus.rs2       = 5'd2;
    sbus.imm       = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  -1, {31'h0, bus.in_ready},  32'h1);
    check("rst_mem_wr_en", -1, {31'h0, bus.mem_wr_en}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready2", -1, {31'h0, bus.in_ready},  32'h1);
    check("rst_mem_wr_en2",-1, {31'h0, bus.mem_wr_en}, 32'h0);
    check("rst_mem_addr",  -1, {22'h0, bus.mem_addr},  32'h0);
    check("rst_mem_wdata", -1, bus.mem_wdata,          32'h0);
    check("rst_count",     -1, {21'h0, count},         32'h0);
    check("rst_full",      -1, {31'h0, full},          32'h0);
    check("rst_opcode_err",-1, {31'h0, opcode_err},    32'h0);
    check("rst_imm_err",   -1, {31'h0, imm_err},       32'h0);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: sw held for 4 WRITE cycles while mem_ready is low 3 of them
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.mem_ready = 1'b0;
    drive_fields(7'h23, 3'h2, 7'h00, 5'd0, 5'd2, 5'd5, 32'h8);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_pack_wr_en", -1, {31'h0, bus.mem_wr_en}, 32'h0);
    check("bp_pack_ready", -1, {31'h0, bus.in_ready},  32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_wr_en",    k, {31'h0, bus.mem_wr_en}, 32'h1);
      check("bp_addr",     k, {22'h0, bus.mem_addr},  32'h0);
      check("bp_wdata",    k, bus.mem_wdata,          32'h00512423);
      check("bp_in_ready", k, {31'h0, bus.in_ready},  32'h0);
      if (k == 3) bus.mem_ready = 1'b1;
    end
    @(negedge clk);
    check("bp_done_wr_en", -1, {31'h0, bus.mem_wr_en}, 32'h0);
    check("bp_done_ready", -1, {31'h0, bus.in_ready},  32'h1);
    check("bp_done_count", -1, {21'h0, count},         32'h1);
    check("bp_done_addr",  -1, {22'h0, bus.mem_addr},  32'h1);

    // clear during WRITE, with a bundle offered in the same cycle
    bus.mem_ready = 1'b0;
    drive_fields(7'h33, 3'h0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("clr_pre_wr_en", -1, {31'h0, bus.mem_wr_en}, 32'h1);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_wr_en",     -1, {31'h0, bus.mem_wr_en}, 32'h0);
    check("clr_count",     -1, {21'h0, count},         32'h0);
    check("clr_addr",      -1, {22'h0, bus.mem_addr},  32'h0);
    check("clr_in_ready",  -1, {31'h0, bus.in_ready},  32'h1);
    @(negedge clk);
    check("clr_no_accept", -1, {31'h0, bus.in_ready},  32'h1);
    check("clr_wr_en2",    -1, {31'h0, bus.mem_wr_en}, 32'h0);

    // Asynchronous reset in the middle of WRITE
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_wr_en", -1, {31'h0, bus.mem_wr_en}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_wr_en", -1, {31'h0, bus.mem_wr_en}, 32'h0);
    check("arst_ready", -1, {31'h0, bus.in_ready},  32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);

    // ADDR_WIDTH = 2: five bundles offered, only four fit
    nwr = 0;
    for (int b = 0; b < 5; b++) begin
      bit ok = 0;
      for (int w = 0; w < 8; w++) begin
        if (sbus.in_ready) begin
          ok = 1;
          break;
        end
        @(negedge clk);
      end
      if (ok) begin
        sbus.in_valid = 1'b1;
        @(negedge clk);
        sbus.in_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
          @(negedge clk);
          if (sbus.mem_wr_en) begin
            check("small_addr", b, {30'h0, sbus.mem_addr}, nwr);
            check("small_data", b, sbus.mem_wdata, 32'h002081B3);
            nwr++;
            break;
          end
        end
      end
    end
    @(negedge clk);
    check("small_nwrites", -1, nwr,                      32'd4);
    check("small_full",    -1, {31'h0, s_full},          32'h1);
    check("small_ready",   -1, {31'h0, sbus.in_ready},   32'h0);
    check("small_count",   -1, {29'h0, s_count},         32'h4);
    s_clear = 1'b1;
    @(negedge clk);
    s_clear = 1'b0;
    check("small_clr_full",  -1, {31'h0, s_full},        32'h0);
    check("small_clr_count", -1, {29'h0, s_count},       32'h0);
    check("small_clr_ready", -1, {31'h0, sbus.in_ready}, 32'h1);
    sbus.in_valid = 1'b1;
    @(negedge clk);
    sbus.in_valid = 1'b0;
    @(negedge clk);
    check("small_again_wr",   -1, {31'h0, sbus.mem_wr_en}, 32'h1);
    check("small_again_addr", -1, {30'h0, sbus.mem_addr},  32'h0);
    @(negedge clk);
    check("small_again_cnt",  -1, {29'h0, s_count},        32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded RV32I instruction fields (opcode, registers, funct3/funct7, 32-bit immediate) back into 32-bit instruction words and writes them sequentially into instruction memory. It is the inverse of instruction decode: testbench and bring-up logic use it to load programs from field-level descriptions. Fields arrive over a valid/ready handshake. Each accepted instruction is written to the next word address.

## Interface
- ADDR_WIDTH, 10: instruction memory word-address width.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; aborts any in-flight instruction, zeroes address, clears flags.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  opcode_t  instruction opcode.
- funct3 / funct7  in  3 / 7  function fields.
- rd / rs1 / rs2  in  5 each  register indices.
- imm  in  imm_t (32)  sign-extended immediate, byte offset as the decoder produces it.
- mem_wr_en  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  encoded instruction.
- full  out  1  sticky; address space exhausted.
- opcode_err  out  1  sticky; an unsupported opcode was received.
- imm_err  out  1  sticky; an immediate was out of range (see Configuration).
- count  out  ADDR_WIDTH+1  number of words written since reset or clear.

## Operation
- The FSM has three states: IDLE, PACK and WRITE.
- **IDLE:** in_ready = !full. When in_valid & in_ready, capture all fields and go to PACK.
- **PACK:** compute the word into the mem_wdata register, then go to WRITE.
  - Unknown opcode (not RType, IType_logic, IType_load, IType_jalr, SType, BType, JType, UType_auipc, UType_lui or FENCE): set opcode_err, return to IDLE, no write.
- **WRITE:** hold mem_wr_en = 1 with mem_addr and mem_wdata stable until mem_ready. On mem_wr_en & mem_ready, increment address and count and return to IDLE.
  - When the address wraps from 2^ADDR_WIDTH−1 to 0, set full.
- Packing rules:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I (logic, load, jalr, FENCE): imm[11:0]|rs1|funct3|rd|op.
  - IType_logic with funct3 001 or 101: [31:25] = funct7 and [24:20] = imm[4:0].
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Fields that the format does not use are ignored.
- clear in any state forces IDLE, mem_wr_en = 0, address = 0, count = 0, and clears all flags. The in-flight bundle is discarded. If in_valid is high in the same cycle as clear, it is not accepted.

## Timing
- Reset values: state IDLE, in_ready 1, mem_wr_en 0, mem_addr 0, mem_wdata 0, count 0, full/opcode_err/imm_err 0.
- Accept in cycle T, then PACK in T+1, then mem_wr_en high from T+2.
- With mem_ready = 1, the write completes in T+2 and in_ready is high again in T+3. Peak throughput is one word per 3 cycles.
- Backpressure: each cycle mem_ready is low extends WRITE by one cycle. Outputs are held stable during that time.
- Rejected bundle (error): in_ready returns in T+2.
- reset_n assertion mid-WRITE drops mem_wr_en immediately, asynchronously.

## Configuration
- IMM_RANGE_CHECK_EN defined: PACK checks the immediate against its format.
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0] = 0.
  - J: imm[31:20] all equal and imm[0] = 0.
  - U: imm[11:0] = 0.
  - On a violation: set imm_err, skip the write, return to IDLE, leave address unchanged.
- IMM_RANGE_CHECK_EN undefined: the immediate is silently truncated to the format, and the imm_err port is tied to 0.

## Structure
- Shared package holds the encoder state enum (IDLE/PACK/WRITE) and an instruction-format enum (R, I, I_SHIFT, S, B, U, J).
- opcode_t and imm_t come from the existing shared types.
- Sub-module instr_packer: purely combinational (format, fields) → 32-bit word plus imm_ok. The FSM instantiates it.

## Test plan
- add x3,x1,x2 (RType, f3 0, f7 0) → write 0x002081B3 at addr 0; count = 1.
- Sequence addi x1,x0,−1 / sw x5,8(x2) / beq x1,x2,−4 / jal x1,2048 / lui x5,0x12345 → 0xFFF00093, 0x00512423, 0xFE208EE3, 0x001000EF, 0x123452B7 at addrs 0–4.
- sw x5,8(x2) accepted, then mem_ready low 3 cycles → mem_wr_en held high 4 cycles with addr/data stable; in_ready low throughout.
- ADDR_WIDTH=2, five bundles offered → four writes at addrs 0–3, then full = 1 and in_ready = 0. clear → full = 0, count = 0, next write at addr 0.
- opcode 7'b1111111 → opcode_err = 1, no mem_wr_en, address unchanged.
- With IMM_RANGE_CHECK_EN, addi imm 2048 → imm_err = 1, no write. Without the macro → 0x80000093 written.
- clear asserted while in WRITE → next cycle mem_wr_en = 0, state IDLE, count 0.
